// File: rtl/rf_vote_ctrl.sv
// Forest vote controller: broadcasts one feature vector to NUM_TREES tree engines,
// collects their classes with a timeout, tallies votes sequentially and reports the winner.
module rf_vote_ctrl #(
    parameter int NUM_TREES     = 6,
    parameter int FEAT_W        = 36,
    parameter int CLASS_W       = 2,
    parameter int NUM_CLASSES   = 3,
    parameter int TIMEOUT       = 64,
    parameter int DEFAULT_CLASS = 0
) (
    input  logic                         sysclk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FEAT_W-1:0]            in_feat,
    output logic [FEAT_W-1:0]            tree_feat,
    output logic [NUM_TREES-1:0]         tree_start,
    input  logic [NUM_TREES-1:0]         tree_done,
    input  logic [NUM_TREES*CLASS_W-1:0] tree_class,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CLASS_W-1:0]           out_class,
    output logic [3:0]                   out_votes,
    output logic                         out_err
);

    localparam int TIDX_W = (NUM_TREES > 1) ? $clog2(NUM_TREES) : 1;
    localparam int CIDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam int IDX_W  = (TIDX_W > CIDX_W) ? TIDX_W : CIDX_W;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_TALLY,
        S_ARGMAX,
        S_OUT
    } state_t;

    state_t                                state_q, state_d;
    logic [FEAT_W-1:0]                     feat_q, feat_d;
    logic [NUM_TREES-1:0]                  done_q, done_d;
    logic [NUM_TREES-1:0][CLASS_W-1:0]     cls_q, cls_d;
    logic [NUM_CLASSES-1:0][3:0]           tally_q, tally_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic                                  err_q, err_d;
    logic [CLASS_W-1:0]                    bestCls_q, bestCls_d;
    logic [3:0]                            bestVotes_q, bestVotes_d;
    logic [CLASS_W-1:0]                    curCls;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            feat_q      <= '0;
            done_q      <= '0;
            cls_q       <= '0;
            tally_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            bestCls_q   <= '0;
            bestVotes_q <= '0;
        end else begin
            state_q     <= state_d;
            feat_q      <= feat_d;
            done_q      <= done_d;
            cls_q       <= cls_d;
            tally_q     <= tally_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            bestCls_q   <= bestCls_d;
            bestVotes_q <= bestVotes_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        feat_d      = feat_q;
        done_d      = done_q;
        cls_d       = cls_q;
        tally_d     = tally_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        err_d       = err_q;
        bestCls_d   = bestCls_q;
        bestVotes_d = bestVotes_q;
        curCls      = cls_q[idx_q];

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    feat_d  = in_feat;
                    done_d  = '0;
                    cls_d   = '0;
                    tally_d = '0;
                    err_d   = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // Only the first done pulse of each tree is captured.
                for (int i = 0; i < NUM_TREES; i++) begin
                    if (tree_done[i] && !done_q[i]) begin
                        done_d[i] = 1'b1;
                        cls_d[i]  = tree_class[i*CLASS_W +: CLASS_W];
                    end
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (&done_d) begin
                    idx_d   = '0;
                    state_d = S_TALLY;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    idx_d   = '0;
                    state_d = S_TALLY;
                end
            end

            S_TALLY: begin
                if (done_q[idx_q]) begin
                    if ({1'b0, curCls} < (CLASS_W+1)'(NUM_CLASSES)) begin
                        tally_d[curCls] = tally_q[curCls] + 4'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (idx_q == IDX_W'(NUM_TREES - 1)) begin
                    idx_d       = '0;
                    bestCls_d   = CLASS_W'(DEFAULT_CLASS);
                    bestVotes_d = '0;
                    state_d     = S_ARGMAX;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_ARGMAX: begin
                // Strictly-greater keeps the lowest index on ties; all-zero keeps the default.
                if (tally_q[idx_q] > bestVotes_q) begin
                    bestCls_d   = CLASS_W'(idx_q);
                    bestVotes_d = tally_q[idx_q];
                end
                if (idx_q == IDX_W'(NUM_CLASSES - 1)) begin
                    state_d = S_OUT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready   = (state_q == S_IDLE);
    assign tree_start = {NUM_TREES{state_q == S_START}};
    assign tree_feat  = feat_q;
    assign out_valid  = (state_q == S_OUT);
    assign out_class  = bestCls_q;
    assign out_votes  = bestVotes_q;
    assign out_err    = err_q;

endmodule

// File: tb/tb_rf_vote_ctrl.sv
// Scoreboard bench for rf_vote_ctrl: directed transactions push expected results,
// an independent monitor compares them whenever the controller presents a result.
module tb_rf_vote_ctrl;

    localparam int NT  = 6;
    localparam int FW  = 36;
    localparam int CW  = 2;
    localparam int TO  = 64;
    localparam logic [7:0] NEVER = 8'd255;

    typedef struct {
        logic [CW-1:0] cls;
        logic [3:0]    votes;
        logic          err;
        int            rise;
    } exp_t;

    logic              sysclk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [FW-1:0]     in_feat = '0;
    logic [FW-1:0]     tree_feat;
    logic [NT-1:0]     tree_start;
    logic [NT-1:0]     tree_done = '0;
    logic [NT*CW-1:0]  tree_class = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [CW-1:0]     out_class;
    logic [3:0]        out_votes;
    logic              out_err;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sbQ[$];

    rf_vote_ctrl #(
        .NUM_TREES(NT), .FEAT_W(FW), .CLASS_W(CW),
        .NUM_CLASSES(3), .TIMEOUT(TO), .DEFAULT_CLASS(0)
    ) dut (
        .sysclk(sysclk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .tree_feat(tree_feat), .tree_start(tree_start),
        .tree_done(tree_done), .tree_class(tree_class),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_votes(out_votes), .out_err(out_err)
    );

    initial forever #5 sysclk = ~sysclk;

    initial forever begin
        @(posedge sysclk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        @(negedge sysclk);
        while (!in_ready && n < 300) begin
            @(negedge sysclk);
            n++;
        end
        if (!in_ready) checkOutput(name, in_ready, 1);
    endtask

    // Tree i raises done at offset off[i] cycles after the start cycle and holds it for
    // hold[i] cycles; its class steps by one each cycle it is held, starting at cls[i].
    task automatic driveTrees(input int j, input logic [NT-1:0][7:0] off,
                              input logic [NT-1:0][3:0] hold, input logic [NT-1:0][CW-1:0] cls);
        logic [NT-1:0][CW-1:0] tc;
        for (int i = 0; i < NT; i++) begin
            tc[i] = cls[i];
            tree_done[i] = 1'b0;
            if (off[i] != NEVER && j >= int'(off[i]) && j < int'(off[i]) + int'(hold[i])) begin
                tree_done[i] = 1'b1;
                tc[i] = cls[i] + CW'(j - int'(off[i]));
            end
        end
        tree_class = tc;
    endtask

    task automatic applyStimulus(input string name, input logic [FW-1:0] feat,
                                 input logic [NT-1:0][7:0] off, input logic [NT-1:0][3:0] hold,
                                 input logic [NT-1:0][CW-1:0] cls, input logic [CW-1:0] eCls,
                                 input logic [3:0] eVotes, input logic eErr, input int readyDelay);
        int s, maxOff, lastJ, n;
        bit missing;
        exp_t e;
        waitIdle({name, "_idle"});
        @(posedge sysclk); #1;
        out_ready = (readyDelay == 0);
        in_valid  = 1'b1;
        in_feat   = feat;
        @(posedge sysclk); #1;
        in_valid = 1'b0;
        s = cyc;
        maxOff = 0; lastJ = 0; missing = 1'b0;
        for (int i = 0; i < NT; i++) begin
            if (off[i] == NEVER) missing = 1'b1;
            else begin
                if (int'(off[i]) > maxOff) maxOff = int'(off[i]);
                if (int'(off[i]) + int'(hold[i]) - 1 > lastJ) lastJ = int'(off[i]) + int'(hold[i]) - 1;
            end
        end
        e.cls = eCls; e.votes = eVotes; e.err = eErr;
        e.rise = (missing || maxOff >= TO) ? s + TO + 10 : s + maxOff + 10;
        sbQ.push_back(e);
        @(negedge sysclk);
        checkOutput({name, "_tree_start"}, tree_start, {NT{1'b1}});
        checkOutput({name, "_tree_feat"}, tree_feat, feat);
        for (int j = 1; j <= lastJ; j++) begin
            @(posedge sysclk); #1;
            driveTrees(j, off, hold, cls);
        end
        @(posedge sysclk); #1;
        tree_done = '0;
        if (readyDelay > 0) begin
            n = 0;
            @(negedge sysclk);
            while (!out_valid && n < 300) begin
                @(negedge sysclk);
                n++;
            end
            if (!out_valid) checkOutput({name, "_valid_timeout"}, out_valid, 1);
            repeat (readyDelay) @(posedge sysclk);
            #1 out_ready = 1'b1;
        end
        waitIdle({name, "_done"});
    endtask

    // Monitor: checks every presented result against the scoreboard head, including first-rise cycle.
    initial begin
        bit prevValid;
        bit readyNext;
        exp_t e;
        prevValid = 1'b0;
        readyNext = 1'b0;
        forever begin
            @(negedge sysclk);
            if (rst) begin
                prevValid = 1'b0;
                readyNext = 1'b0;
            end else begin
                if (readyNext) begin
                    checkOutput("in_ready_after_handshake", in_ready, 1);
                    readyNext = 1'b0;
                end
                if (out_valid) begin
                    if (sbQ.size() == 0) begin
                        checkOutput("unexpected_out_valid", out_valid, 0);
                    end else begin
                        e = sbQ[0];
                        if (!prevValid) checkOutput("latency_cycle", cyc, e.rise);
                        checkOutput("out_class", out_class, e.cls);
                        checkOutput("out_votes", out_votes, e.votes);
                        checkOutput("out_err", out_err, e.err);
                        checkOutput("in_ready_during_out", in_ready, 0);
                        if (out_ready) begin
                            void'(sbQ.pop_front());
                            readyNext = 1'b1;
                        end
                    end
                end
                prevValid = out_valid;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_tree_start", tree_start, 0);
        checkOutput("reset_tree_feat", tree_feat, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_class", out_class, 0);
        checkOutput("reset_out_votes", out_votes, 0);
        checkOutput("reset_out_err", out_err, 0);
        @(posedge sysclk); #1 rst = 1'b0;

        // Packed vectors list tree 5 first, tree 0 last.
        applyStimulus("unanimous", 36'h123456789,
            {8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3}, {NT{4'd1}},
            {2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2}, 2'd2, 4'd6, 1'b0, 0);

        applyStimulus("tie_111222", 36'hABCDEF012,
            {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2}, {NT{4'd1}},
            {2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1}, 2'd1, 4'd3, 1'b0, 0);

        applyStimulus("tie_002211", 36'h000FFF000,
            {8'd2, 8'd4, 8'd1, 8'd5, 8'd3, 8'd2}, {NT{4'd1}},
            {2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0}, 2'd0, 4'd2, 1'b0, 0);

        applyStimulus("timeout", 36'hFFF000FFF,
            {NEVER, NEVER, 8'd5, 8'd5, 8'd5, 8'd5}, {NT{4'd1}},
            {2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2}, 2'd2, 4'd2, 1'b1, 0);

        applyStimulus("done_on_timeout", 36'h5A5A5A5A5,
            {8'd64, NEVER, 8'd2, 8'd2, 8'd2, 8'd2}, {NT{4'd1}},
            {2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1}, 2'd1, 4'd2, 1'b1, 0);

        applyStimulus("illegal_all", 36'h111222333,
            {8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2}, {NT{4'd1}},
            {2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3}, 2'd0, 4'd0, 1'b1, 0);

        applyStimulus("backpressure", 36'h987654321,
            {8'd6, 8'd6, 8'd6, 8'd6, 8'd6, 8'd3}, {4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd4},
            {2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1}, 2'd0, 4'd2, 1'b0, 5);

        // Abort a transaction mid-WAIT with three trees already done.
        waitIdle("reset_test_idle");
        @(posedge sysclk); #1;
        in_valid = 1'b1;
        in_feat  = 36'hDEADBEEF0;
        @(posedge sysclk); #1;
        in_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            @(posedge sysclk); #1;
            driveTrees(j, {NEVER, NEVER, NEVER, 8'd2, 8'd2, 8'd2}, {NT{4'd8}},
                       {2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1});
        end
        rst = 1'b1;
        @(posedge sysclk); #1;
        rst = 1'b0;
        tree_done = '0;
        @(negedge sysclk);
        checkOutput("abort_in_ready", in_ready, 1);
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_tree_feat", tree_feat, 0);
        repeat (20) @(negedge sysclk);

        applyStimulus("after_abort", 36'h0F0F0F0F0,
            {8'd4, 8'd3, 8'd2, 8'd1, 8'd2, 8'd3}, {NT{4'd1}},
            {2'd2, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2}, 2'd1, 4'd3, 1'b0, 0);

        repeat (5) @(negedge sysclk);
        checkOutput("scoreboard_drained", sbQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
